sram_row_streamer: RTL and testbench
====================================

SRAM_ROW_STREAMER -- requirements
Module: sram_row_streamer

Interface
REQ-001 SHALL have parameter BWIDTH, default 256, SRAM row width in bits.
REQ-002 SHALL have parameter AWIDTH, default 10, SRAM row-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries (minimum 2).
REQ-004 SHALL have port CLK  input  1  sole clock, all state updates on the rising edge.
REQ-005 SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse that launches a transfer.
REQ-007 SHALL have port base_addr  input  AWIDTH  first row address, sampled with start.
REQ-008 SHALL have port num_rows  input  AWIDTH+1  row count, sampled with start.
REQ-009 SHALL have port busy  output  1  high from the accepted start through the final output beat.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port CSn  output  1  SRAM chip select, active low.
REQ-012 SHALL have port WEn  output  1  SRAM write enable, active low, driven constant 1.
REQ-013 SHALL have port ADDR  output  AWIDTH  SRAM row address.
REQ-014 SHALL have port BE  output  BWIDTH  SRAM bit enable, driven all ones.
REQ-015 SHALL have port D_in  output  BWIDTH  SRAM write data, driven all zeros.
REQ-016 SHALL have port D_out  input  BWIDTH  SRAM read data, valid in the same cycle CSn=0 and WEn=1.
REQ-017 SHALL have port m_valid  output  1  stream beat valid.
REQ-018 SHALL have port m_ready  input  1  stream sink ready.
REQ-019 SHALL have port m_data  output  BWIDTH  stream row data.
REQ-020 SHALL have port m_last  output  1  marks the final row of the transfer.

Function
REQ-021 SHALL implement states IDLE, RUN and DRAIN, with busy=0 only in IDLE.
REQ-022 IDLE: start=1 with num_rows!=0 SHALL latch base_addr and num_rows and enter RUN; start=1 with num_rows=0 SHALL stay in IDLE, issue no read, and pulse done the next cycle.
REQ-023 RUN: CSn SHALL be 0 in a cycle only if (FIFO occupancy + reads in flight) < FIFO_DEPTH; ADDR SHALL hold the current read address.
REQ-024 Each cycle with CSn=0 SHALL capture D_out into the FIFO at the closing rising edge, then advance the address by the stride modulo 2^AWIDTH, with wrap from 2^AWIDTH-1 to 0 permitted.
REQ-025 After num_rows reads have issued, the block SHALL enter DRAIN and hold CSn=1.
REQ-026 DRAIN SHALL return to IDLE on the handshake (m_valid & m_ready) of the m_last beat, and done SHALL pulse in the following cycle.
REQ-027 Latency: with start sampled at edge E0, CSn SHALL go low after E0, and m_valid SHALL go high after E1.
REQ-028 With m_ready held at 1, the block SHALL sustain one row per cycle.
REQ-029 m_valid, m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-030 The FIFO SHALL never overflow; a read SHALL never issue when the FIFO is full with no beat leaving in the same cycle.
REQ-031 A pop and a push in the same cycle SHALL leave occupancy unchanged and SHALL preserve row order.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 m_last SHALL be 1 only on beat number num_rows.

Reset
REQ-034 While RSTn=0, the outputs SHALL be: state=IDLE, CSn=1, ADDR=0, busy=0, done=0, m_valid=0, m_last=0, m_data=0, FIFO empty.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer immediately; the aborted transfer SHALL produce no done pulse and no further beats.

Configuration
REQ-036 With SRAM_STRM_STRIDE_EN defined, the block SHALL have input port stride, AWIDTH bits, sampled with start, and the address SHALL advance by stride (stride=0 re-reads base_addr).
REQ-037 Without SRAM_STRM_STRIDE_EN, the stride port SHALL be absent and the address SHALL advance by 1.

Verification
REQ-038 base_addr=5, num_rows=4, m_ready=1 -> CSn low 4 consecutive cycles with ADDR 5,6,7,8; 4 beats back-to-back; m_last on beat 4; done pulse 1 cycle after.
REQ-039 num_rows=3, m_ready=0 for 10 cycles then 1 -> at most FIFO_DEPTH reads issue before the stall; m_data held stable; rows emerge in order 0,1,2 with none lost.
REQ-040 base_addr=1022, num_rows=4 (AWIDTH=10) -> ADDR sequence 1022,1023,0,1.
REQ-041 num_rows=0 -> no CSn assertion; busy stays 0; done pulses once.
REQ-042 RSTn low after beat 2 of an 8-row transfer -> CSn=1 and m_valid=0 immediately; no done; a new start after reset runs cleanly.
REQ-043 With SRAM_STRM_STRIDE_EN defined, base_addr=0, stride=16, num_rows=3 -> ADDR sequence 0,16,32.

Source files
------------

// File: rtl/sram_row_streamer.sv
// sram_row_streamer: reads num_rows consecutive (or strided) rows from a single-port SRAM
// and presents them as a valid/ready stream, buffered by a small FIFO so the sink can stall.
//
// Optional feature: define SRAM_STRM_STRIDE_EN to add the stride input (address step
// sampled with start). Without it the address steps by 1.
//
// Ports:
//   CLK, RSTn            clock, asynchronous active-low reset
//   start                one-cycle launch pulse (ignored while busy)
//   base_addr, num_rows  first row and row count, sampled with start
//   stride               address step, sampled with start (SRAM_STRM_STRIDE_EN only)
//   busy, done           transfer in progress / one-cycle completion pulse
//   CSn, WEn, ADDR       SRAM control (read only, WEn tied high)
//   BE, D_in             SRAM bit enable (all ones) and write data (all zeros)
//   D_out                SRAM read data, valid in the cycle CSn=0
//   m_valid, m_ready     stream handshake
//   m_data, m_last       stream row data and final-row marker
module sram_row_streamer #(
    parameter int unsigned BWIDTH     = 256,
    parameter int unsigned AWIDTH     = 10,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   num_rows,
`ifdef SRAM_STRM_STRIDE_EN
    input  logic [AWIDTH-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic              CSn,
    output logic              WEn,
    output logic [AWIDTH-1:0] ADDR,
    output logic [BWIDTH-1:0] BE,
    output logic [BWIDTH-1:0] D_in,
    input  logic [BWIDTH-1:0] D_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BWIDTH-1:0] m_data,
    output logic              m_last
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AWIDTH:0] ONE_ROW = 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   left_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              done_q;
    logic [BWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic [AWIDTH-1:0] step;

    logic issue;
    logic pop;
    logic final_issue;

`ifdef SRAM_STRM_STRIDE_EN
    logic [AWIDTH-1:0] step_q;
    assign step = step_q;
`else
    assign step = {{(AWIDTH-1){1'b0}}, 1'b1};
`endif

    // Read data is combinational off the SRAM, so a read is in flight only during its own
    // cycle; occupancy alone bounds issue and the FIFO can never overflow.
    always_comb begin
        issue       = (state_q == StRun) && (count_q < CW'(FIFO_DEPTH));
        pop         = (count_q != '0) && m_ready;
        final_issue = issue && (left_q == ONE_ROW);
    end

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            left_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            last_q   <= '0;
`ifdef SRAM_STRM_STRIDE_EN
            step_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= base_addr;
                            left_q  <= num_rows;
`ifdef SRAM_STRM_STRIDE_EN
                            step_q  <= stride;
`endif
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        addr_q <= addr_q + step;
                        left_q <= left_q - ONE_ROW;
                        if (final_issue) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // The final row is pushed on the edge that enters this state, so the
                    // last beat always leaves from here.
                    if (pop && m_last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (issue) begin
                last_q[wr_ptr_q] <= final_issue;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            unique case ({issue, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Row storage needs no reset: m_data is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (issue) mem_q[wr_ptr_q] <= D_out;
    end

    always_comb begin
        busy    = (state_q != StIdle);
        done    = done_q;
        CSn     = ~issue;
        WEn     = 1'b1;
        ADDR    = addr_q;
        BE      = '1;
        D_in    = '0;
        m_valid = (count_q != '0);
        m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
        m_last  = m_valid & last_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_sram_row_streamer.sv
module tb_sram_row_streamer;

    localparam int BW = 256;
    localparam int AW = 10;
    localparam int FD = 2;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_rows = '0;
    logic [AW-1:0] stride = 1;
    logic          busy, done, CSn, WEn, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] ADDR;
    logic [BW-1:0] BE, D_in, D_out, m_data;

    sram_row_streamer #(.BWIDTH(BW), .AWIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
`ifdef SRAM_STRM_STRIDE_EN
        .stride(stride),
`endif
        .busy(busy), .done(done), .CSn(CSn), .WEn(WEn), .ADDR(ADDR), .BE(BE), .D_in(D_in),
        .D_out(D_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic checkv(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] row_val(input logic [AW-1:0] a);
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = {22'h0, a} * 32'h9E3779B1 + 32'(i);
        return v;
    endfunction

    // Combinational SRAM model.
    always_comb D_out = row_val(ADDR);

    typedef struct {
        logic [BW-1:0] data;
        bit            last;
    } beat_t;

    beat_t         sb[$];
    bit            mon_en = 0;
    int            k = 0;
    logic [AW-1:0] exp_addr, exp_step;
    int            exp_left, beats, done_cnt, done_k;

    always @(negedge CLK) begin
        if (mon_en) begin
            int occ;
            occ = sb.size();
            checkv("m_valid", BW'(m_valid), BW'(occ != 0));
            checkv("const_outputs", BW'({WEn, BE == '1, D_in == '0}), BW'(3'b111));
            if (m_valid && occ != 0) begin
                checkv("m_data", m_data, sb[0].data);
                checkv("m_last", BW'(m_last), BW'(sb[0].last));
                if (m_ready) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
            if (!CSn) begin
                checkv("sram_addr", BW'(ADDR), BW'(exp_addr));
                checkv("issue_room", BW'(occ < FD), BW'(1));
                checkv("extra_read", BW'(exp_left > 0), BW'(1));
                if (exp_left > 0) begin
                    sb.push_back('{data: row_val(exp_addr), last: (exp_left == 1)});
                    exp_addr = exp_addr + exp_step;
                    exp_left--;
                end
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
        end
    end

    task automatic arm(input int base, input int n, input int stp, input int stall);
        @(posedge CLK);
        #1;
        sb.delete();
        exp_addr  = AW'(base);
`ifdef SRAM_STRM_STRIDE_EN
        exp_step  = AW'(stp);
`else
        exp_step  = AW'(1);
`endif
        exp_left  = n;
        beats     = 0;
        done_cnt  = 0;
        done_k    = -1;
        k         = 0;
        base_addr = AW'(base);
        num_rows  = (AW+1)'(n);
        stride    = AW'(stp);
        m_ready   = (stall == 0);
        start     = 1'b1;
        mon_en    = 1;
    endtask

    task automatic run_xfer(input int base, input int n, input int stp, input int stall,
                            input int exp_done_k);
        arm(base, n, stp, stall);
        while (k < 200 && !(done_k >= 0 && k >= done_k + 3)) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            k++;
            m_ready = (k > stall);
            if (k == 1) checkv("busy_after_start", BW'(busy), BW'(n != 0));
            if (k == 2 && n > 0) begin
                // A second start while busy must be ignored.
                start     = 1'b1;
                base_addr = AW'(base + 77);
                num_rows  = (AW+1)'(n + 5);
            end
        end
        mon_en = 0;
        checkv("done_cycle", BW'(done_k), BW'(exp_done_k));
        checkv("done_count", BW'(done_cnt), BW'(1));
        checkv("beat_count", BW'(beats), BW'(n));
        checkv("reads_left", BW'(exp_left), BW'(0));
        checkv("sb_empty", BW'(sb.size()), BW'(0));
        checkv("busy_end", BW'(busy), BW'(0));
    endtask

    typedef struct {
        int base;
        int n;
        int stall;
        int exp_done_k;
    } vec_t;

    vec_t vecs[6];

    task automatic check_reset_outputs(input string tag);
        checkv({tag, "_CSn"}, BW'(CSn), BW'(1));
        checkv({tag, "_ADDR"}, BW'(ADDR), BW'(0));
        checkv({tag, "_busy"}, BW'(busy), BW'(0));
        checkv({tag, "_done"}, BW'(done), BW'(0));
        checkv({tag, "_m_valid"}, BW'(m_valid), BW'(0));
        checkv({tag, "_m_last"}, BW'(m_last), BW'(0));
        checkv({tag, "_m_data"}, m_data, '0);
    endtask

    initial begin
        int seen_done;
        int guard;

        vecs[0] = '{base: 5,    n: 4, stall: 0,  exp_done_k: 6};
        vecs[1] = '{base: 1022, n: 4, stall: 0,  exp_done_k: 6};
        vecs[2] = '{base: 0,    n: 3, stall: 10, exp_done_k: 14};
        vecs[3] = '{base: 100,  n: 1, stall: 0,  exp_done_k: 3};
        vecs[4] = '{base: 7,    n: 0, stall: 0,  exp_done_k: 1};
        vecs[5] = '{base: 50,   n: 5, stall: 3,  exp_done_k: 9};

        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].base, vecs[i].n, 1, vecs[i].stall, vecs[i].exp_done_k);
        end

`ifdef SRAM_STRM_STRIDE_EN
        run_xfer(0, 3, 16, 0, 5);
        run_xfer(9, 3, 0, 0, 5);
`endif

        // Abort an 8-row transfer after its second beat.
        arm(200, 8, 1, 0);
        guard = 0;
        while (beats < 2 && guard < 50) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            k++;
            guard++;
        end
        checkv("abort_reached_beat2", BW'(beats), BW'(2));
        mon_en = 0;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("abort");
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (done) seen_done++;
            if (c == 4) begin
                #1;
                RSTn = 1'b1;
            end
        end
        checkv("abort_no_done", BW'(seen_done), BW'(0));
        checkv("abort_idle_valid", BW'(m_valid), BW'(0));
        run_xfer(300, 3, 1, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
